pe_nic: RTL and testbench
=========================

# pe_nic

Network interface between a processing element (PE) and the PE port pair of a ring/mesh router. It is the endpoint of the router's PE channels: it injects PE packets into the router's PE input channel (send/ready/data) and ejects packets from the router's PE output channel. It exposes four memory-mapped registers to the PE: one receive buffer, one transmit buffer and two status registers. Injection is gated by the router's even/odd virtual-channel polarity.

## Interface
Parameters:
- DATA_WIDTH, 64, packet width. Bit 63 is the VC bit.

Ports:
- clk  in  1  system clock. All state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset. 0 = reset.
- addr  in  2  register select: 0 = RX_DATA, 1 = RX_STATUS, 2 = TX_DATA, 3 = TX_STATUS.
- d_in  in  64  PE write data.
- d_out  out  64  PE read data, registered.
- nic_en  in  1  register access strobe.
- nic_wr_en  in  1  1 = write, 0 = read. Qualified by nic_en.
- polarity_in  in  1  router polarity, toggling every cycle.
- pesi  out  1  send to router PE input channel.
- pedi  out  64  packet to router PE input channel.
- peri  in  1  router PE input channel ready.
- peso  in  1  router PE output channel send.
- pedo  in  64  packet from router PE output channel.
- pero  out  1  ready to router PE output channel.

## Operation
- State: tx_buf[63:0], tx_full, tx_drop (sticky), rx_buf[63:0], rx_full, d_out register.
- Reset (reset=0, asynchronous): all state and d_out = 0. Outputs are forced to pesi=0, pedi=0 and pero=0 while reset is low.

PE writes (nic_en=1, nic_wr_en=1):
- addr 2 with tx_full=0: tx_buf<=d_in, tx_full<=1.
- addr 2 with tx_full=1: data is discarded, tx_drop<=1. A write in the same cycle the buffer drains is still discarded, because tx_full was 1 when it was sampled.
- addr 0, 1, 3: ignored.

PE reads (nic_en=1, nic_wr_en=0), return values:
- addr 0: d_out<=rx_buf, and rx_full<=0. Reading with rx_full=0 returns the stale rx_buf and does not change state.
- addr 1: d_out<={63'b0, rx_full}.
- addr 3: d_out<={62'b0, tx_drop, tx_full}, and tx_drop<=0. A drop event in the same cycle wins, so tx_drop stays 1.
- No read access: d_out holds its value.

Injection (combinational from registered state):
- pesi = tx_full & peri & (polarity_in == tx_buf[63]).
- pedi = pesi ? tx_buf : 0.
- When pesi=1: tx_full<=0 on the next edge.

Ejection:
- pero = ~rx_full, with reset high.
- When peso & pero: rx_buf<=pedo, rx_full<=1.
- If peso=1 while pero=0, the packet is not accepted. The router holds it.
- A read of addr 0 and a new arrival in the same cycle cannot occur, because pero=0 while rx_full=1. pero rises the cycle after the read.

## Timing
- Write to TX_DATA → pesi can assert in the next cycle, at the earliest, once peri=1 and the polarity matches. Worst case is two cycles after the write plus any peri stall.
- Read latency: d_out is valid on the cycle after the read strobe.
- Ejection: a packet accepted at edge N is readable at RX_DATA from the access at edge N+1 onward. RX_STATUS reads 1 from N+1.
- Throughput: one packet per direction per two cycles. This is bounded by polarity for TX and by the read round trip for RX.
- Reset mid-transfer: a buffered packet is lost, pesi/pero drop immediately, and no partial state remains.

## Test plan
- Reset: hold reset=0 with random inputs → d_out=0, pesi=0, pedi=0, pero=0. Release → pero=1.
- Injection polarity: write 64'h8000_0000_0000_00AA with peri=1 → pesi rises only in a cycle with polarity_in=1, pedi=that value for exactly one cycle, then TX_STATUS reads 0.
- Backpressure and drop: peri=0, write 64'h1, then write 64'h2 → TX_STATUS reads 2'b11, then 2'b01 on a re-read. Raise peri → 64'h1 is sent and 64'h2 never appears.
- Ejection: peso=1 with pedo=64'h0123_4567_89AB_CDEF → pero falls next cycle, RX_STATUS=1, RX_DATA read returns the value, pero=1 the cycle after the read.
- RX full stall: a second peso with 64'h5 while rx_full=1 → not accepted, rx_buf unchanged. After the RX_DATA read, 64'h5 is accepted.
- Async reset mid-operation: assert reset between clock edges with tx_full=1 and rx_full=1 → both clear immediately, and a TX_STATUS read after release returns 0.

Source files
------------

// File: rtl/pe_nic.sv
// Network interface between a PE and a router's PE channel pair: one TX and
// one RX packet buffer, memory-mapped to the PE, with polarity-gated injection.
module pe_nic #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nic_en,
  input  logic                  nic_wr_en,
  input  logic                  polarity_in,
  output logic                  pesi,
  output logic [DATA_WIDTH-1:0] pedi,
  input  logic                  peri,
  input  logic                  peso,
  input  logic [DATA_WIDTH-1:0] pedo,
  output logic                  pero
);

  localparam logic [1:0] ADDR_RX_DATA   = 2'd0;
  localparam logic [1:0] ADDR_RX_STATUS = 2'd1;
  localparam logic [1:0] ADDR_TX_DATA   = 2'd2;
  localparam logic [1:0] ADDR_TX_STATUS = 2'd3;

  logic [DATA_WIDTH-1:0] tx_buf_reg, tx_buf_next;
  logic                  tx_full_reg, tx_full_next;
  logic                  tx_drop_reg, tx_drop_next;
  logic [DATA_WIDTH-1:0] rx_buf_reg, rx_buf_next;
  logic                  rx_full_reg, rx_full_next;
  logic [DATA_WIDTH-1:0] d_out_reg, d_out_next;

  logic wr_tx;
  logic rd_en;
  logic rx_accept;

  assign wr_tx = nic_en & nic_wr_en & (addr == ADDR_TX_DATA);
  assign rd_en = nic_en & ~nic_wr_en;

  // Outputs are gated by reset so they drop the instant reset asserts.
  assign pesi      = reset & tx_full_reg & peri & (polarity_in == tx_buf_reg[DATA_WIDTH-1]);
  assign pedi      = pesi ? tx_buf_reg : '0;
  assign pero      = reset & ~rx_full_reg;
  assign rx_accept = peso & pero;
  assign d_out     = d_out_reg;

  always_comb begin
    tx_buf_next  = tx_buf_reg;
    tx_full_next = tx_full_reg;
    tx_drop_next = tx_drop_reg;
    rx_buf_next  = rx_buf_reg;
    rx_full_next = rx_full_reg;
    d_out_next   = d_out_reg;

    if (pesi) begin
      tx_full_next = 1'b0;
    end

    if (rd_en) begin
      case (addr)
        ADDR_RX_DATA: begin
          d_out_next   = rx_buf_reg;
          rx_full_next = 1'b0;
        end
        ADDR_RX_STATUS: d_out_next = {{(DATA_WIDTH-1){1'b0}}, rx_full_reg};
        ADDR_TX_STATUS: begin
          d_out_next   = {{(DATA_WIDTH-2){1'b0}}, tx_drop_reg, tx_full_reg};
          tx_drop_next = 1'b0;
        end
        default: d_out_next = d_out_reg;
      endcase
    end

    // Fullness is judged on the registered flag, so a write in the draining
    // cycle is still dropped; a drop also overrides a same-cycle status clear.
    if (wr_tx) begin
      if (tx_full_reg) begin
        tx_drop_next = 1'b1;
      end else begin
        tx_buf_next  = d_in;
        tx_full_next = 1'b1;
      end
    end

    if (rx_accept) begin
      rx_buf_next  = pedo;
      rx_full_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_buf_reg  <= '0;
      tx_full_reg <= 1'b0;
      tx_drop_reg <= 1'b0;
      rx_buf_reg  <= '0;
      rx_full_reg <= 1'b0;
      d_out_reg   <= '0;
    end else begin
      tx_buf_reg  <= tx_buf_next;
      tx_full_reg <= tx_full_next;
      tx_drop_reg <= tx_drop_next;
      rx_buf_reg  <= rx_buf_next;
      rx_full_reg <= rx_full_next;
      d_out_reg   <= d_out_next;
    end
  end

endmodule

// File: tb/tb_pe_nic.sv
// Scoreboard bench for pe_nic: drivers push expected reads and injected
// packets into queues; a monitor pops and compares as the DUT presents them.
module tb_pe_nic;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [63:0] d_in = '0;
  logic [63:0] d_out;
  logic        nic_en = 1'b0;
  logic        nic_wr_en = 1'b0;
  logic        polarity_in = 1'b0;
  logic        pesi;
  logic [63:0] pedi;
  logic        peri = 1'b0;
  logic        peso = 1'b0;
  logic [63:0] pedo = '0;
  logic        pero;

  int n_checks = 0;
  int n_pass = 0;

  logic [63:0] rd_q[$];
  logic [63:0] tx_q[$];

  pe_nic #(.DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nic_en(nic_en), .nic_wr_en(nic_wr_en), .polarity_in(polarity_in),
    .pesi(pesi), .pedi(pedi), .peri(peri), .peso(peso), .pedo(pedo), .pero(pero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) #2 polarity_in = ~polarity_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("check %s: got %h", name, act);
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: reads complete one edge after the strobe; pesi marks a send.
  initial begin
    logic        rd_fire;
    logic [63:0] e;
    forever begin
      @(posedge clk);
      rd_fire = reset & nic_en & ~nic_wr_en;
      @(negedge clk);
      if (rd_fire) begin
        if (rd_q.size() == 0) begin
          n_checks++;
          $display("FAIL rd_unexpected: got %h expected none", d_out);
        end else begin
          e = rd_q.pop_front();
          check("rd_data", d_out, e);
        end
      end
      if (pesi) begin
        if (tx_q.size() == 0) begin
          n_checks++;
          $display("FAIL tx_unexpected: got %h expected none", pedi);
        end else begin
          e = tx_q.pop_front();
          check("tx_pkt", pedi, e);
          check("tx_polarity", {63'b0, polarity_in}, {63'b0, e[63]});
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [63:0] e);
    rd_q.push_back(e);
    addr = a; nic_en = 1'b1; nic_wr_en = 1'b0;
    cyc();
    nic_en = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] v);
    addr = a; d_in = v; nic_en = 1'b1; nic_wr_en = 1'b1;
    cyc();
    nic_en = 1'b0; nic_wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random activity on every input
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      addr = 2'($urandom); d_in = {$urandom, $urandom}; nic_en = 1'($urandom);
      nic_wr_en = 1'($urandom); peri = 1'($urandom); peso = 1'($urandom);
      pedo = {$urandom, $urandom};
      #3;
      check("rst_d_out", d_out, 64'h0);
      check("rst_pesi", {63'b0, pesi}, 64'h0);
      check("rst_pedi", pedi, 64'h0);
      check("rst_pero", {63'b0, pero}, 64'h0);
    end
    cyc();
    nic_en = 1'b0; nic_wr_en = 1'b0; peri = 1'b0; peso = 1'b0;
    reset = 1'b1;
    cyc();
    check("post_rst_pero", {63'b0, pero}, 64'h1);
    rd(2'd3, 64'h0);
    rd(2'd1, 64'h0);

    // Injection gated by polarity
    peri = 1'b1;
    tx_q.push_back(64'h8000_0000_0000_00AA);
    wr(2'd2, 64'h8000_0000_0000_00AA);
    cyc(3);
    rd(2'd3, 64'h0);
    tx_q.push_back(64'h0000_0000_0000_0055);
    wr(2'd2, 64'h0000_0000_0000_0055);
    cyc(3);
    rd(2'd3, 64'h0);

    // Backpressure and drop
    peri = 1'b0;
    wr(2'd2, 64'h1);
    wr(2'd2, 64'h2);
    rd(2'd3, 64'h3);
    rd(2'd3, 64'h1);
    tx_q.push_back(64'h1);
    peri = 1'b1;
    cyc(4);
    rd(2'd3, 64'h0);

    // Ejection
    peso = 1'b1; pedo = 64'h0123_4567_89AB_CDEF;
    cyc();
    peso = 1'b0;
    check("eject_pero_low", {63'b0, pero}, 64'h0);
    rd(2'd1, 64'h1);
    rd(2'd0, 64'h0123_4567_89AB_CDEF);
    check("eject_pero_high", {63'b0, pero}, 64'h1);
    rd(2'd1, 64'h0);

    // RX full stall: router holds 5 until the buffer is read
    peso = 1'b1; pedo = 64'hAB;
    cyc();
    pedo = 64'h5;
    cyc(2);
    rd(2'd1, 64'h1);
    rd(2'd0, 64'hAB);
    cyc();
    peso = 1'b0;
    rd(2'd1, 64'h1);
    rd(2'd0, 64'h5);
    rd(2'd0, 64'h5);

    // Asynchronous reset with both buffers occupied
    peri = 1'b0;
    wr(2'd2, 64'h77);
    peso = 1'b1; pedo = 64'h9;
    cyc();
    peso = 1'b0;
    check("pre_rst_pero", {63'b0, pero}, 64'h0);
    peri = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("midrst_pero", {63'b0, pero}, 64'h0);
    check("midrst_pesi", {63'b0, pesi}, 64'h0);
    check("midrst_d_out", d_out, 64'h0);
    cyc(2);
    reset = 1'b1;
    cyc();
    check("midrst_release_pero", {63'b0, pero}, 64'h1);
    rd(2'd3, 64'h0);
    rd(2'd1, 64'h0);
    rd(2'd0, 64'h0);
    cyc(4);

    check("rd_q_drained", 64'(rd_q.size()), 64'h0);
    check("tx_q_drained", 64'(tx_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
